// File: rtl/ififo_ctrl_pkg.sv
// ififo_ctrl_pkg: shared state encoding and default sizes for the input-FIFO read sequencer.
package ififo_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RUN} state_e;
  localparam int COL_DEF = 8;
  localparam int LW_DEF  = 8;
  localparam int PERF_W  = 32;
endpackage

// File: rtl/ififo_skew_ctrl.sv
// ififo_skew_ctrl: skewed per-column FIFO read sequencer feeding the systolic array.
// Optional busy/stall performance counters are built when IFIFO_SKEW_CTRL_PERF_EN is defined.
module ififo_skew_ctrl
  import ififo_ctrl_pkg::*;
#(
  parameter int col = COL_DEF,
  parameter int lw  = LW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [lw-1:0]     len,
  input  logic              stall,
  input  logic [col-1:0]    valid_col,
  output logic [col-1:0]    rd_en,
  output logic              busy,
  output logic              done
`ifdef IFIFO_SKEW_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] busy_cycles,
  output logic [PERF_W-1:0] stall_cycles
`endif
);
  state_e          state_q, state_d;
  logic [lw:0]     t_q, t_d;
  logic [lw-1:0]   len_q, len_d;
  logic            done_q, done_d;
  logic [col-1:0]  due;
  logic [lw:0]     last;
  logic            hold;
  for (genvar c = 0; c < col; c++) begin : g_due
    localparam logic [lw:0] CV = (lw+1)'(c);
    assign due[c] = (t_q >= CV) && ((t_q - CV) < {1'b0, len_q});
  end
  // Only columns currently due can stall the wavefront; all columns freeze together.
  assign hold  = stall | |(due & ~valid_col);
  assign last  = {1'b0, len_q} + (lw+1)'(col) - (lw+1)'(2);
  assign rd_en = (state_q == RUN) ? due & {col{~hold}} : '0;
  assign busy  = state_q != IDLE;
  assign done  = done_q;
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d   = (len != '0) ? len : len_q;
        state_d = (len != '0) ? WAIT : IDLE;
        done_d  = len == '0;
      end
      WAIT: begin
        t_d     = '0;
        state_d = &valid_col ? RUN : WAIT;
      end
      RUN: if (!hold) begin
        t_d     = t_q + 1'b1;
        state_d = (t_q == last) ? IDLE : RUN;
        done_d  = t_q == last;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end
`ifdef IFIFO_SKEW_CTRL_PERF_EN
  logic [PERF_W-1:0] busy_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= (busy && ~&busy_cnt_q) ? busy_cnt_q + 1'b1 : busy_cnt_q;
      stall_cnt_q <= (state_q == RUN && hold && ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end
  end
  assign busy_cycles  = busy_cnt_q;
  assign stall_cycles = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ififo_skew_ctrl.sv
// tb_ififo_skew_ctrl: directed checks of skewed read sequencing, holds, zero-length and reset abort.
module tb_ififo_skew_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       stall = 1'b0;
  logic [7:0] valid_col = 8'hFF;
  logic [7:0] rd_en;
  logic       busy, done;
`ifdef IFIFO_SKEW_CTRL_PERF_EN
  logic [31:0] busy_cycles, stall_cycles;
`endif
  int total = 0;
  int bad = 0;
  int cnt [8];
  logic [7:0] hist [32];
  int done_r;
  logic busy_done, wait_busy, busy_seen;
  logic [7:0] wait_rd;

  ififo_skew_ctrl #(.col(8), .lw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .stall(stall),
    .valid_col(valid_col), .rd_en(rd_en), .busy(busy), .done(done)
`ifdef IFIFO_SKEW_CTRL_PERF_EN
    , .busy_cycles(busy_cycles), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // r counts RUN cycles: start is driven at r=-2, WAIT is r=-1, RUN cycle 0 is r=0.
  task automatic run_cmd(input logic [7:0] l, input int st0, input int stn, input int dcol,
                         input int d0, input int dn, input int ign, input int rst_r);
    done_r = -99;
    busy_done = 1'bx;
    busy_seen = 1'b0;
    wait_busy = 1'bx;
    wait_rd = 8'hxx;
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    for (int i = 0; i < 32; i++) hist[i] = 8'h00;
    for (int r = -2; r < 40; r++) begin
      @(posedge clk);
      #2;
      start = (r == -2) || (r == ign);
      len = l;
      stall = (r >= st0) && (r < st0 + stn);
      valid_col = 8'hFF;
      if (r >= d0 && r < d0 + dn) valid_col[dcol] = 1'b0;
      #2;
      for (int c = 0; c < 8; c++) cnt[c] += int'(rd_en[c]);
      if (r >= 0 && r < 32) hist[r] = rd_en;
      if (r == -1) begin
        wait_busy = busy;
        wait_rd = rd_en;
      end
      busy_seen = busy_seen | busy;
      if (r == rst_r) begin
        chk("rst_pre_rd", {24'd0, rd_en}, 32'h78);
        reset = 1'b0;
        #1;
        chk("rst_async_rd", {24'd0, rd_en}, 32'h0);
        chk("rst_async_busy", {31'd0, busy}, 32'h0);
        chk("rst_async_done", {31'd0, done}, 32'h0);
        break;
      end
      if (done) begin
        done_r = r;
        busy_done = busy;
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    valid_col = 8'hFF;
  endtask

  task automatic chk_cnt(input string tag);
    for (int c = 0; c < 8; c++) chk($sformatf("%s_cnt%0d", tag, c), cnt[c], 32'd4);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #2;
    chk("reset_rd", {24'd0, rd_en}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    chk("reset_done", {31'd0, done}, 32'h0);
    do_reset();

    // scenario 1: plain len=4
    run_cmd(8'd4, -99, 0, 0, -99, 0, -99, -99);
    chk("s1_wait_busy", {31'd0, wait_busy}, 32'h1);
    chk("s1_wait_rd", {24'd0, wait_rd}, 32'h0);
    chk("s1_rd0", {24'd0, hist[0]}, 32'h01);
    chk("s1_rd3", {24'd0, hist[3]}, 32'h0F);
    chk("s1_rd4", {24'd0, hist[4]}, 32'h1E);
    chk("s1_rd7", {24'd0, hist[7]}, 32'hF0);
    chk("s1_rd10", {24'd0, hist[10]}, 32'h80);
    chk("s1_done_cycle", done_r, 32'd11);
    chk("s1_done_busy", {31'd0, busy_done}, 32'h0);
    chk_cnt("s1");
    @(posedge clk);
    #4;
    chk("s1_done_pulse", {31'd0, done}, 32'h0);

    // scenario 2: stall RUN cycles 2..4 (fresh reset so perf counters start at zero)
    do_reset();
    run_cmd(8'd4, 2, 3, 0, -99, 0, -99, -99);
    chk("s2_rd1", {24'd0, hist[1]}, 32'h03);
    chk("s2_rd2", {24'd0, hist[2]}, 32'h00);
    chk("s2_rd4", {24'd0, hist[4]}, 32'h00);
    chk("s2_rd5", {24'd0, hist[5]}, 32'h07);
    chk("s2_rd13", {24'd0, hist[13]}, 32'h80);
    chk("s2_done_cycle", done_r, 32'd14);
    chk_cnt("s2");
`ifdef IFIFO_SKEW_CTRL_PERF_EN
    chk("s6_stall_cycles", stall_cycles, 32'd3);
    chk("s6_busy_cycles", busy_cycles, 32'd15);
`endif

    // scenario 3: column 5 runs dry at RUN cycles 5..6
    run_cmd(8'd4, -99, 0, 5, 5, 2, -99, -99);
    chk("s3_rd4", {24'd0, hist[4]}, 32'h1E);
    chk("s3_rd5", {24'd0, hist[5]}, 32'h00);
    chk("s3_rd6", {24'd0, hist[6]}, 32'h00);
    chk("s3_rd7", {24'd0, hist[7]}, 32'h3C);
    chk("s3_done_cycle", done_r, 32'd13);
    chk_cnt("s3");

    // scenario 4: zero-length command
    run_cmd(8'd0, -99, 0, 0, -99, 0, -99, -99);
    chk("s4_done_cycle", done_r, 32'hFFFFFFFF);
    chk("s4_busy_seen", {31'd0, busy_seen}, 32'h0);
    chk("s4_rd_total", cnt[0] + cnt[3] + cnt[7], 32'd0);

    // scenario 5: reset at RUN cycle 6, then a command with an ignored start while busy
    run_cmd(8'd4, -99, 0, 0, -99, 0, -99, 6);
    @(posedge clk);
    #2;
    chk("s5_no_done", {31'd0, done}, 32'h0);
    chk("s5_rst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;
    run_cmd(8'd4, -99, 0, 0, -99, 0, 3, -99);
    chk("s5_done_cycle", done_r, 32'd11);
    chk_cnt("s5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
